// File: rtl/delay_sum_beamformer_mc.sv
// Multi-channel delay-and-sum beamformer: per-channel circular delay lines, shared write pointer,
// registered delayed samples and a registered full-precision sum. Optional macro BF_APODIZATION_EN adds per-channel Q1.7 weights.
module delay_sum_beamformer_mc #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_DELAY = 64,
    parameter int SUM_W     = DATA_W + $clog2(NUM_CH),
    localparam int AW       = $clog2(MAX_DELAY),
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [AW-1:0]            cfg_delay,
`ifdef BF_APODIZATION_EN
    input  logic [7:0]               cfg_weight,
`endif
    output logic [SUM_W-1:0]         out_data,
    output logic                     out_valid
);

    localparam logic [AW:0] FILL_MAX = (AW+1)'(MAX_DELAY);
    localparam logic [AW:0] WARM     = (AW+1)'(MAX_DELAY - 1);

    logic signed [DATA_W-1:0] mem [NUM_CH][MAX_DELAY];
    logic [AW-1:0]            wr_ptr;
    logic [AW:0]              fill_cnt;
    logic [AW-1:0]            delay_r [NUM_CH];
    logic [AW-1:0]            rd_addr [NUM_CH];
    logic signed [DATA_W-1:0] rd_sample [NUM_CH];
    logic signed [DATA_W-1:0] s1_data [NUM_CH];
    logic                     s1_valid;
    logic signed [SUM_W-1:0]  sum;
    logic                     sum_valid;
    logic [31:0]              cfg_ch_ext;

    assign cfg_ch_ext = 32'(cfg_ch);

    // Buffer contents are never reset; the fill counter masks stale entries.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                mem[c][wr_ptr] <= in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else if (in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill_cnt != FILL_MAX) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // Delay zero bypasses the buffer so the sample being written this cycle is used.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            rd_addr[c] = wr_ptr - delay_r[c];
            if (delay_r[c] == '0) begin
                rd_sample[c] = in_data[c*DATA_W +: DATA_W];
            end else begin
                rd_sample[c] = mem[c][rd_addr[c]];
            end
        end
    end

`ifdef BF_APODIZATION_EN
    logic [7:0]             weight_r [NUM_CH];
    logic signed [DATA_W:0] w_data [NUM_CH];
    logic                   w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                delay_r[c]  <= '0;
                weight_r[c] <= 8'd128;
            end
        end else if (cfg_we) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (cfg_ch_ext == c) begin
                    delay_r[c]  <= cfg_delay;
                    weight_r[c] <= cfg_weight;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                delay_r[c] <= '0;
            end
        end else if (cfg_we) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (cfg_ch_ext == c) begin
                    delay_r[c] <= cfg_delay;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                s1_data[c] <= '0;
            end
        end else begin
            s1_valid <= in_valid && (fill_cnt >= WARM);
            if (in_valid) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    s1_data[c] <= rd_sample[c];
                end
            end
        end
    end

`ifdef BF_APODIZATION_EN
    // Q1.7 weighting: product shifted right 7 (floor), fits DATA_W+1 bits for weights up to 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                w_data[c] <= '0;
            end
        end else begin
            w_valid <= s1_valid;
            if (s1_valid) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    w_data[c] <= (DATA_W+1)'(((DATA_W+9)'(s1_data[c]) *
                                 (DATA_W+9)'($signed({1'b0, weight_r[c]}))) >>> 7);
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            sum = sum + SUM_W'(w_data[c]);
        end
    end
    assign sum_valid = w_valid;
`else
    always_comb begin
        sum = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            sum = sum + SUM_W'(s1_data[c]);
        end
    end
    assign sum_valid = s1_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= sum_valid;
            if (sum_valid) begin
                out_data <= sum;
            end
        end
    end

endmodule

// File: tb/tb_delay_sum_beamformer_mc.sv
// Bench for delay_sum_beamformer_mc: directed and random stimulus against a sample-history reference model.
// Builds with or without BF_APODIZATION_EN.
module tb_delay_sum_beamformer_mc;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 16;
    localparam int MAX_DELAY = 64;
    localparam int SUM_W     = 18;
    localparam int AW        = 6;
    localparam int CH_W      = 2;
`ifdef BF_APODIZATION_EN
    localparam int LAT  = 3;
    localparam bit APOD = 1'b1;
`else
    localparam int LAT  = 2;
    localparam bit APOD = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     cfg_we;
    logic [CH_W-1:0]          cfg_ch;
    logic [AW-1:0]            cfg_delay;
    logic [7:0]               cfg_weight;
    logic [SUM_W-1:0]         out_data;
    logic                     out_valid;

    delay_sum_beamformer_mc #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_DELAY(MAX_DELAY), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
`ifdef BF_APODIZATION_EN
        .cfg_weight(cfg_weight),
`endif
        .out_data(out_data), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference model: full history of accepted samples, indexed by absolute sample number.
    int               hist [NUM_CH][$];
    int               m_delay [NUM_CH];
    int               m_weight [NUM_CH];
    int               m_count;
    bit               pq_v [$];
    int               pq_s [$];
    bit               exp_valid;
    logic [SUM_W-1:0] exp_data;
    int               checks = 0;
    int               errors = 0;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            hist[c].delete();
            m_delay[c]  = 0;
            m_weight[c] = 128;
        end
        m_count = 0;
        pq_v.delete();
        pq_s.delete();
        exp_valid = 1'b0;
        exp_data  = '0;
    endtask

    task automatic check_out(input string tag);
        checks++;
        assert (out_valid === exp_valid) else begin
            errors++;
            $error("FAIL %s out_valid got %0b want %0b", tag, out_valid, exp_valid);
        end
        checks++;
        assert (out_data === exp_data) else begin
            errors++;
            $error("FAIL %s out_data got %0d want %0d", tag, $signed(out_data), $signed(exp_data));
        end
    endtask

    task automatic lit(input string tag, input int want);
        logic [SUM_W-1:0] w;
        w = SUM_W'(want);
        checks++;
        assert (out_valid === 1'b1 && out_data === w) else begin
            errors++;
            $error("FAIL %s out_valid=%0b out_data=%0d want valid=1 data=%0d",
                   tag, out_valid, $signed(out_data), want);
        end
    endtask

    task automatic step(input bit iv, input logic [NUM_CH*DATA_W-1:0] data,
                        input bit we, input int ch, input int dl, input int wt);
        int  s;
        int  x;
        int  idx;
        bit  v;
        in_valid   = iv;
        in_data    = data;
        cfg_we     = we;
        cfg_ch     = CH_W'(ch);
        cfg_delay  = AW'(dl);
        cfg_weight = 8'(wt);
        s = 0;
        v = 1'b0;
        if (iv) begin
            for (int c = 0; c < NUM_CH; c++) begin
                x = $signed(data[c*DATA_W +: DATA_W]);
                hist[c].push_back(x);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                idx = m_count - m_delay[c];
                x = (idx >= 0) ? hist[c][idx] : 0;
                s += (x * m_weight[c]) >>> 7;
            end
            v = (m_count >= MAX_DELAY - 1);
            m_count++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        if (we && ch < NUM_CH) begin
            m_delay[ch]  = dl;
            m_weight[ch] = APOD ? wt : 128;
        end
        pq_v.push_back(v);
        pq_s.push_back(s);
        if (pq_v.size() > LAT - 1) begin
            exp_valid = pq_v.pop_front();
            s = pq_s.pop_front();
            if (exp_valid) exp_data = SUM_W'(s);
        end else begin
            exp_valid = 1'b0;
        end
        check_out("cycle");
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        rst_n    = 1'b0;
        #1;
        exp_valid = 1'b0;
        exp_data  = '0;
        check_out("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] bcast(input int v);
        logic [NUM_CH*DATA_W-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = DATA_W'(v);
        return r;
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] rnd_data();
        logic [NUM_CH*DATA_W-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = DATA_W'($urandom);
        return r;
    endfunction

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_delay  = '0;
        cfg_weight = 8'd128;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int n = 0; n < 70; n++) begin
            step(1'b1, bcast(n), 1'b0, 0, 0, 128);
            if (n == 64) lit("first_valid", 252);
            if (n == 65) lit("second_valid", 256);
        end

        for (int c = 0; c < NUM_CH; c++) step(1'b0, '0, 1'b1, c, c, 128);
        for (int n = 70; n < 131; n++) begin
            step(1'b1, bcast(n), 1'b0, 0, 0, 128);
            if (n == 101) lit("delay_ramp", 394);
        end

        for (int n = 131; n < 206; n++) begin
            step(1'b1, bcast(n), n == 200, 1, 5, 128);
            if (n == 201) lit("cfg_old_delay", 794);
            if (n == 202) lit("cfg_new_delay", 794);
            if (n == 203) lit("cfg_after", 798);
        end

        for (int i = 0; i < 140; i++) step(i % 2 == 0, rnd_data(), 1'b0, 0, 0, 128);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 7) == 0,
                 $urandom_range(0, NUM_CH - 1), $urandom_range(0, MAX_DELAY - 1), 128);
        end

        for (int c = 0; c < NUM_CH; c++) step(1'b0, '0, 1'b1, c, 0, 128);
        for (int i = 0; i < 70; i++) step(1'b1, bcast(-32768), 1'b0, 0, 0, 128);
        lit("neg_full", -131072);

        do_reset();
        for (int n = 0; n < 70; n++) begin
            step(1'b1, bcast(n), 1'b0, 0, 0, 128);
            if (n == 64) lit("rewarm", 252);
        end

`ifdef BF_APODIZATION_EN
        step(1'b0, '0, 1'b1, 0, 0, 128);
        step(1'b0, '0, 1'b1, 1, 0, 64);
        step(1'b0, '0, 1'b1, 2, 0, 0);
        step(1'b0, '0, 1'b1, 3, 0, 128);
        for (int i = 0; i < 10; i++) step(1'b1, bcast(100), 1'b0, 0, 0, 128);
        lit("apod_weights", 250);
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 7) == 0,
                 $urandom_range(0, NUM_CH - 1), $urandom_range(0, MAX_DELAY - 1),
                 $urandom_range(0, 255));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
